// File: rtl/e1_pkg.sv
// Shared E1 transmit framing constants, FSM state type, position struct and
// the timeslot-to-channel mapping.
package e1_pkg;

  localparam int unsigned E1_NUM_CH   = 30;
  localparam int unsigned E1_NUM_TS   = 32;
  localparam int unsigned E1_MF_LEN   = 16;
  localparam int unsigned E1_BITS     = 8;
  localparam int unsigned E1_CH_W     = E1_NUM_CH * 8;
  localparam int unsigned E1_SIG_W    = E1_NUM_CH * 4;
  localparam int unsigned E1_BIT_W    = 3;
  localparam int unsigned E1_TS_W     = 5;
  localparam int unsigned E1_FRM_W    = 4;
  localparam int unsigned E1_CH_IDX_W = 5;

  localparam logic [7:0] E1_FAS      = 8'h9B;
  localparam logic [7:0] E1_NFAS     = 8'hDF;
  localparam logic [7:0] E1_MFAS     = 8'h0B;
  localparam logic [7:0] E1_CAS_IDLE = 8'hDD;

  typedef enum logic {
    AIS = 1'b0,
    RUN = 1'b1
  } e1_tx_state_t;

  typedef struct packed {
    logic [E1_FRM_W-1:0] frm;
    logic [E1_TS_W-1:0]  ts;
    logic [E1_BIT_W-1:0] bit_idx;
  } e1_pos_t;

  // Voice timeslots 1-15 carry ch0-14, 17-31 carry ch15-29; TS0/TS16 have no channel.
  function automatic logic [E1_CH_IDX_W-1:0] e1_ts_to_ch(input logic [E1_TS_W-1:0] ts);
    if (ts < 5'd16) return ts - 5'd1;
    else            return ts - 5'd2;
  endfunction

endpackage

// File: rtl/e1_mux_tx_if.sv
// Payload/line bundle between the E1 transmit framer and its environment.
interface e1_mux_tx_if;
  import e1_pkg::*;

  logic                bit_en;
  logic                tx_en;
  logic [E1_CH_W-1:0]  ch_data;
  logic [E1_SIG_W-1:0] sig;
  logic                ch_load;
  logic                ser_out;
  logic                frame_start;
  logic                mframe_start;
  logic                running;

  modport master (
    output bit_en, tx_en, ch_data, sig,
    input  ch_load, ser_out, frame_start, mframe_start, running
  );

  modport slave (
    input  bit_en, tx_en, ch_data, sig,
    output ch_load, ser_out, frame_start, mframe_start, running
  );

endinterface

// File: rtl/e1_tx_pos_cnt.sv
// Free-running bit/timeslot/frame position chain; points at the next bit to drive.
module e1_tx_pos_cnt
  import e1_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    en_i,
  output e1_pos_t pos_o
);

  e1_pos_t pos_q, pos_d;
  logic    bit_wrap, ts_wrap, frm_wrap;

  always_comb begin
    bit_wrap = (pos_q.bit_idx == 3'(E1_BITS - 1));
    ts_wrap  = (pos_q.ts == 5'(E1_NUM_TS - 1));
    frm_wrap = (pos_q.frm == 4'(E1_MF_LEN - 1));
    pos_d    = pos_q;
    if (en_i) begin
      pos_d.bit_idx = bit_wrap ? '0 : pos_q.bit_idx + 3'd1;
      if (bit_wrap) begin
        pos_d.ts = ts_wrap ? '0 : pos_q.ts + 5'd1;
        if (ts_wrap) pos_d.frm = frm_wrap ? '0 : pos_q.frm + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/e1_mux_tx.sv
// E1 G.704 transmit framer: shadow-buffered payload, FAS/NFAS/MFAS insertion, AIS/RUN FSM.
// Define E1_CAS_EN to carry CAS signalling in TS16; otherwise TS16 sends idle 8'hDD.
module e1_mux_tx
  import e1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  e1_mux_tx_if.slave  bus
);

  e1_pos_t                pos;
  e1_tx_state_t           state_q, state_d;
  logic [E1_CH_W-1:0]     ch_q, ch_d;
  logic                   ser_q, ser_d;
  logic                   fs_q, fs_d, mfs_q, mfs_d, ld_q, ld_d, run_q, run_d;
  logic                   frame_edge_c;
  logic [E1_CH_IDX_W-1:0] ch_idx_c;
  logic [7:0]             tx_byte_c;

  e1_tx_pos_cnt u_pos (
    .clk   (clk),
    .rst   (rst),
    .en_i  (bus.bit_en),
    .pos_o (pos)
  );

  assign frame_edge_c = bus.bit_en && (pos.ts == 5'd0) && (pos.bit_idx == 3'd0);
  assign ch_idx_c     = e1_ts_to_ch(pos.ts);

`ifdef E1_CAS_EN
  logic [E1_SIG_W-1:0] sig_q, sig_d;
  logic [3:0]          sig_a_c, sig_b_c;

  // TS16 of frame n pairs ABCD of ch n-1 (high nibble) with ch n+14 (low nibble).
  always_comb begin
    sig_d   = frame_edge_c ? bus.sig : sig_q;
    sig_a_c = sig_q[{pos.frm - 4'd1, 2'b00} +: 4];
    sig_b_c = sig_q[{5'(pos.frm) + 5'd14, 2'b00} +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= {E1_NUM_CH{4'hD}};
    else     sig_q <= sig_d;
  end
`else
  logic unused_sig_c;
  assign unused_sig_c = ^bus.sig;
`endif

  // Byte for the current timeslot; at TS0 the byte never depends on the buffer being captured.
  always_comb begin
    tx_byte_c = ch_q[{ch_idx_c, 3'b000} +: 8];
    if (pos.ts == 5'd0) begin
      tx_byte_c = pos.frm[0] ? E1_NFAS : E1_FAS;
    end else if (pos.ts == 5'd16) begin
      if (pos.frm == 4'd0) tx_byte_c = E1_MFAS;
`ifdef E1_CAS_EN
      else                 tx_byte_c = {sig_a_c, sig_b_c};
`else
      else                 tx_byte_c = E1_CAS_IDLE;
`endif
    end
  end

  // Next state and registered outputs; transitions only at frame boundaries.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ser_d   = ser_q;
    fs_d    = frame_edge_c;
    ld_d    = frame_edge_c;
    mfs_d   = frame_edge_c && (pos.frm == 4'd0);
    if (frame_edge_c) begin
      ch_d = bus.ch_data;
      unique case (state_q)
        AIS: if (bus.tx_en && (pos.frm == 4'd0)) state_d = RUN;
        RUN: if (!bus.tx_en)                     state_d = AIS;
        default: state_d = AIS;
      endcase
    end
    if (bus.bit_en) ser_d = (state_d == RUN) ? tx_byte_c[~pos.bit_idx] : 1'b1;
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= AIS;
      ch_q    <= {E1_NUM_CH{8'hFF}};
      ser_q   <= 1'b1;
      fs_q    <= 1'b0;
      mfs_q   <= 1'b0;
      ld_q    <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ser_q   <= ser_d;
      fs_q    <= fs_d;
      mfs_q   <= mfs_d;
      ld_q    <= ld_d;
      run_q   <= run_d;
    end
  end

  assign bus.ser_out      = ser_q;
  assign bus.frame_start  = fs_q;
  assign bus.mframe_start = mfs_q;
  assign bus.ch_load      = ld_q;
  assign bus.running      = run_q;

endmodule

// File: tb/tb_e1_mux_tx.sv
// Directed self-checking bench for e1_mux_tx; TS16 expectations follow E1_CAS_EN.
module tb_e1_mux_tx;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_fs, n_mfs, n_ld;
  logic fs0, mfs0, ld0, run0, run_last;
  logic [7:0] fb [32];

  e1_mux_tx_if bus ();

  e1_mux_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < 30; k++) bus.ch_data[8*k +: 8] = base + 8'(k + 1);
    bus.sig        = '0;
    bus.sig[3:0]   = 4'h1;
    bus.sig[63:60] = 4'h2;
  endtask

  task automatic clk_cycle(input logic en);
    bus.bit_en = en;
    @(posedge clk);
    #1;
    if (bus.frame_start)  n_fs++;
    if (bus.mframe_start) n_mfs++;
    if (bus.ch_load)      n_ld++;
    bus.bit_en = 1'b0;
  endtask

  // Collects one 256-bit frame; optional tx_en drop / data change at a timeslot.
  task automatic get_frame(input int gate, input int drop_ts, input int chg_ts);
    n_fs = 0; n_mfs = 0; n_ld = 0;
    for (int b = 0; b < 256; b++) begin
      if (b == drop_ts * 8) bus.tx_en = 1'b0;
      if (b == chg_ts * 8)  set_data(8'h40);
      clk_cycle(1'b1);
      if (b == 0) begin
        fs0 = bus.frame_start; mfs0 = bus.mframe_start;
        ld0 = bus.ch_load;     run0 = bus.running;
      end
      fb[b/8] = {fb[b/8][6:0], bus.ser_out};
      repeat (gate - 1) clk_cycle(1'b0);
    end
    run_last = bus.running;
  endtask

`ifdef E1_CAS_EN
  localparam logic [7:0] EXP_TS16_F1 = 8'h12;
  localparam logic [7:0] EXP_TS16_F2 = 8'h00;
`else
  localparam logic [7:0] EXP_TS16_F1 = 8'hDD;
  localparam logic [7:0] EXP_TS16_F2 = 8'hDD;
`endif

  initial begin
    int ones, fs_first, fs_last, run_seen;
    n_checks = 0; n_errors = 0;
    n_fs = 0; n_mfs = 0; n_ld = 0;
    rst = 1'b1;
    bus.bit_en = 1'b0;
    bus.tx_en  = 1'b0;
    set_data(8'h00);
    #23;
    check_eq("rst_ser_out", 32'(bus.ser_out), 32'd1);
    check_eq("rst_ch_load", 32'(bus.ch_load), 32'd0);
    check_eq("rst_frame_start", 32'(bus.frame_start), 32'd0);
    check_eq("rst_mframe_start", 32'(bus.mframe_start), 32'd0);
    check_eq("rst_running", 32'(bus.running), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // AIS idle: 512 bits all ones, frame pulses at bit 0 and 256
    ones = 0; fs_first = -1; fs_last = -1; run_seen = 0;
    n_fs = 0; n_mfs = 0; n_ld = 0;
    for (int i = 0; i < 512; i++) begin
      clk_cycle(1'b1);
      if (bus.ser_out) ones++;
      if (bus.running) run_seen++;
      if (bus.frame_start) begin
        if (fs_first < 0) fs_first = i;
        fs_last = i;
      end
    end
    check_eq("ais_ones", 32'(ones), 32'd512);
    check_eq("ais_fs_count", 32'(n_fs), 32'd2);
    check_eq("ais_fs_first", 32'(fs_first), 32'd0);
    check_eq("ais_fs_period", 32'(fs_last), 32'd256);
    check_eq("ais_mfs_count", 32'(n_mfs), 32'd1);
    check_eq("ais_running", 32'(run_seen), 32'd0);

    // tx_en raised in frame 2: stays AIS until the multiframe wraps
    bus.tx_en = 1'b1;
    run_seen = 0; n_mfs = 0; ones = 0;
    for (int i = 0; i < 3584; i++) begin
      clk_cycle(1'b1);
      if (bus.running) run_seen++;
      if (bus.ser_out) ones++;
    end
    check_eq("wait_running", 32'(run_seen), 32'd0);
    check_eq("wait_mfs", 32'(n_mfs), 32'd0);
    check_eq("wait_ones", 32'(ones), 32'd3584);

    // frame 0 of the multiframe
    get_frame(1, -1, -1);
    check_eq("f0_mfs", 32'(mfs0), 32'd1);
    check_eq("f0_fs", 32'(fs0), 32'd1);
    check_eq("f0_ld", 32'(ld0), 32'd1);
    check_eq("f0_running", 32'(run0), 32'd1);
    check_eq("f0_ts0", 32'(fb[0]), 32'h9B);
    check_eq("f0_ts1", 32'(fb[1]), 32'h01);
    check_eq("f0_ts15", 32'(fb[15]), 32'h0F);
    check_eq("f0_ts16", 32'(fb[16]), 32'h0B);
    check_eq("f0_ts17", 32'(fb[17]), 32'h10);
    check_eq("f0_ts31", 32'(fb[31]), 32'h1E);
    check_eq("f0_fs_width", 32'(n_fs), 32'd1);

    // frame 1: new ch_data applied at ts5 must not disturb this frame
    get_frame(1, -1, 5);
    check_eq("f1_ts0", 32'(fb[0]), 32'hDF);
    check_eq("f1_ts16", 32'(fb[16]), 32'(EXP_TS16_F1));
    check_eq("f1_ts17", 32'(fb[17]), 32'h10);
    check_eq("f1_ts31", 32'(fb[31]), 32'h1E);
    check_eq("f1_ld_count", 32'(n_ld), 32'd1);
    check_eq("f1_mfs_count", 32'(n_mfs), 32'd0);

    // frame 2 carries the new payload
    get_frame(1, -1, -1);
    check_eq("f2_ts0", 32'(fb[0]), 32'h9B);
    check_eq("f2_ts1", 32'(fb[1]), 32'h41);
    check_eq("f2_ts16", 32'(fb[16]), 32'(EXP_TS16_F2));
    check_eq("f2_ts31", 32'(fb[31]), 32'h5E);
    check_eq("f2_ld_count", 32'(n_ld), 32'd1);

    // frame 3: tx_en dropped at ts5, frame still completes
    get_frame(1, 5, -1);
    check_eq("f3_ts0", 32'(fb[0]), 32'hDF);
    check_eq("f3_ts1", 32'(fb[1]), 32'h41);
    check_eq("f3_ts31", 32'(fb[31]), 32'h5E);
    check_eq("f3_running_end", 32'(run_last), 32'd1);

    // frame 4: AIS
    get_frame(1, -1, -1);
    check_eq("f4_ts0", 32'(fb[0]), 32'hFF);
    check_eq("f4_ts1", 32'(fb[1]), 32'hFF);
    check_eq("f4_running", 32'(run0), 32'd0);
    check_eq("f4_fs", 32'(fs0), 32'd1);

    // reset, then a gated 1-in-4 frame straight into RUN
    bus.tx_en = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    get_frame(4, -1, -1);
    check_eq("g_mfs", 32'(mfs0), 32'd1);
    check_eq("g_running", 32'(run0), 32'd1);
    check_eq("g_ts0", 32'(fb[0]), 32'h9B);
    check_eq("g_ts1", 32'(fb[1]), 32'h41);
    check_eq("g_ts16", 32'(fb[16]), 32'h0B);
    check_eq("g_ts31", 32'(fb[31]), 32'h5E);
    check_eq("g_fs_width", 32'(n_fs), 32'd1);
    check_eq("g_ld_width", 32'(n_ld), 32'd1);
    check_eq("g_mfs_width", 32'(n_mfs), 32'd1);

    // three bits of NFAS (1,1,0), then asynchronous reset mid-frame
    for (int i = 0; i < 3; i++) begin
      clk_cycle(1'b1);
      repeat (3) clk_cycle(1'b0);
    end
    check_eq("g_nfas_bit2", 32'(bus.ser_out), 32'd0);
    check_eq("g_running_mid", 32'(bus.running), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_ser_out", 32'(bus.ser_out), 32'd1);
    check_eq("arst_running", 32'(bus.running), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_fs = 0; n_mfs = 0; n_ld = 0;
    clk_cycle(1'b1);
    check_eq("post_fs", 32'(bus.frame_start), 32'd1);
    check_eq("post_mfs", 32'(bus.mframe_start), 32'd1);
    check_eq("post_ld", 32'(bus.ch_load), 32'd1);
    check_eq("post_ser_bit7", 32'(bus.ser_out), 32'd1);
    clk_cycle(1'b1);
    check_eq("post_ser_bit6", 32'(bus.ser_out), 32'd0);
    check_eq("post_fs_cleared", 32'(bus.frame_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
